uart_r: RTL and testbench

- UART receiver, the far end of the team's one-bit-per-clock UART transmitter (14-bit payload, no baud divider).
- Deserialises a frame from `rx`: start bit 0, D_WIDTH data bits LSB first, stop bit 1.
- Checks the stop bit, then presents the word on a valid/ready output register toward the consumer.

---
 rtl/uart_r.sv | 135 +++++++++++++
 tb/tb_uart_r.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_r.sv
// uart_r: UART receiver for a one-bit-per-clock serial link.
// Frame format: start bit 0, D_WIDTH data bits LSB first, stop bit 1.
// Good words are presented on a valid/ready output register.
// Optional macro UART_R_SYNC_EN: when defined, rx passes through a two-flop
// synchroniser before sampling. This adds two cycles of latency from the pin.
module uart_r #(
  parameter int D_WIDTH = 14,
  parameter int C_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic               rx_ready,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  output logic               rx_busy,
  output logic               rx_frame_err,
  output logic               rx_overrun
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] DATA      = 2'd1;
  localparam logic [1:0] STOP      = 2'd2;
  localparam logic [1:0] WAIT_IDLE = 2'd3;

  localparam logic [C_WIDTH-1:0] LAST_BIT = C_WIDTH'(D_WIDTH - 1);

  logic               rx_s;
  logic [1:0]         state_reg, state_next;
  logic [C_WIDTH-1:0] cnt_reg, cnt_next;
  logic [D_WIDTH-1:0] shift_reg, shift_next;
  logic [D_WIDTH-1:0] data_reg, data_next;
  logic               valid_reg, valid_next;
  logic               busy_reg, busy_next;
  logic               err_reg, err_next;
  logic               ovr_reg, ovr_next;

`ifdef UART_R_SYNC_EN
  logic [1:0] sync_reg;

  // Two-flop synchroniser. It resets to the idle line level so that reset
  // release is not mistaken for a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_reg <= 2'b11;
    else      sync_reg <= {sync_reg[0], rx};
  end

  assign rx_s = sync_reg[1];
`else
  assign rx_s = rx;
`endif

  // Frame FSM together with the output handshake.
  // Consuming a word and completing a new good frame can happen on the same
  // edge; in that case the new word wins and valid stays high.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    busy_next  = busy_reg;
    err_next   = 1'b0;
    ovr_next   = 1'b0;

    if (valid_reg && rx_ready) valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = DATA;
          cnt_next   = '0;
          busy_next  = 1'b1;
        end
      end
      DATA: begin
        shift_next = {rx_s, shift_reg[D_WIDTH-1:1]};
        if (cnt_reg == LAST_BIT) state_next = STOP;
        else                     cnt_next   = cnt_reg + 1'b1;
      end
      STOP: begin
        busy_next = 1'b0;
        if (rx_s) begin
          state_next = IDLE;
          if (!valid_reg || rx_ready) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
          end else begin
            ovr_next = 1'b1;
          end
        end else begin
          err_next   = 1'b1;
          state_next = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // A held-low line (break) must return high before a new start bit
        // can be recognised.
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State registers. Asynchronous reset abandons any frame in progress
  // without raising an error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
      ovr_reg   <= ovr_next;
    end
  end

  assign rx_data      = data_reg;
  assign rx_valid     = valid_reg;
  assign rx_busy      = busy_reg;
  assign rx_frame_err = err_reg;
  assign rx_overrun   = ovr_reg;

endmodule

// File: tb/tb_uart_r.sv
// tb_uart_r: directed testbench for uart_r in the default build, where the
// receiver samples rx directly.
module tb_uart_r;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        rx_ready;
  logic [13:0] rx_data;
  logic        rx_valid;
  logic        rx_busy;
  logic        rx_frame_err;
  logic        rx_overrun;

  int tests = 0;
  int fails = 0;
  int busy_cnt, err_cnt, ovr_cnt;

  uart_r #(.D_WIDTH(14), .C_WIDTH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, then settle 1 ns past it.
  // Also accumulate how often each status output was seen high.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rx_busy)      busy_cnt++;
    if (rx_frame_err) err_cnt++;
    if (rx_overrun)   ovr_cnt++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Send one complete frame: start bit, 14 data bits LSB first, then the stop bit.
  // rx_ready is held high only on the edge that samples the stop bit.
  task automatic send_frame(input logic [13:0] d, input logic stop_bit, input logic rdy_at_stop);
    busy_cnt = 0;
    err_cnt  = 0;
    ovr_cnt  = 0;
    rx = 1'b0;
    tick();
    for (int i = 0; i < 14; i++) begin
      rx = d[i];
      tick();
    end
    rx       = stop_bit;
    rx_ready = rdy_at_stop;
    tick();
    rx_ready = 1'b0;
  endtask

  initial begin
    // Reset held low while rx toggles: outputs must stay at their reset values.
    rst = 1'b0;
    rx = 1'b1;
    rx_ready = 1'b0;
    busy_cnt = 0;
    err_cnt = 0;
    ovr_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      rx = ~rx;
      tick();
    end
    check("rst_valid", rx_valid, 0);
    check("rst_busy", rx_busy, 0);
    check("rst_data", rx_data, 0);
    check("rst_err_pulses", err_cnt, 0);
    check("rst_ovr_pulses", ovr_cnt, 0);

    // Release reset and hold the line idle.
    rst = 1'b1;
    rx = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 5; i++) tick();
    check("idle_busy_cycles", busy_cnt, 0);
    check("idle_valid", rx_valid, 0);

    // Good frame 14'h2A5C with rx_ready low.
    send_frame(14'h2A5C, 1'b1, 1'b0);
    check("good_valid", rx_valid, 1);
    check("good_data", rx_data, 14'h2A5C);
    check("good_busy_cycles", busy_cnt, 15);
    check("good_busy_after_stop", rx_busy, 0);
    check("good_no_err", err_cnt, 0);

    // Consume the word.
    rx_ready = 1'b1;
    rx = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("consume_valid", rx_valid, 0);
    check("consume_data_kept", rx_data, 14'h2A5C);

    // Frame 14'h1FFF with a bad stop bit, then the line is held low.
    send_frame(14'h1FFF, 1'b0, 1'b0);
    check("ferr_pulse", rx_frame_err, 1);
    check("ferr_valid", rx_valid, 0);
    busy_cnt = 0;
    rx = 1'b0;
    tick();
    check("ferr_one_cycle", rx_frame_err, 0);
    for (int i = 0; i < 3; i++) tick();
    check("ferr_break_no_start", busy_cnt, 0);
    rx = 1'b1;
    tick();
    check("ferr_pulse_count", err_cnt, 1);
    check("ferr_busy_after_break", rx_busy, 0);
    check("ferr_valid_after", rx_valid, 0);

    // Two back-to-back good frames with rx_ready low: the second overruns.
    send_frame(14'h0001, 1'b1, 1'b0);
    check("ovr_first_data", rx_data, 14'h0001);
    send_frame(14'h3FFE, 1'b1, 1'b0);
    check("ovr_pulse", rx_overrun, 1);
    check("ovr_data_kept", rx_data, 14'h0001);
    check("ovr_valid", rx_valid, 1);
    rx = 1'b1;
    tick();
    check("ovr_one_cycle", rx_overrun, 0);
    check("ovr_pulse_count", ovr_cnt, 1);

    // Empty the register, then repeat with rx_ready high on the second stop edge.
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    check("ovr2_drained", rx_valid, 0);
    send_frame(14'h0001, 1'b1, 1'b0);
    send_frame(14'h3FFE, 1'b1, 1'b1);
    check("ovr2_data", rx_data, 14'h3FFE);
    check("ovr2_valid", rx_valid, 1);
    check("ovr2_no_overrun", ovr_cnt, 0);

    // Reset mid-frame after 6 data bits, while a valid word is held.
    rx = 1'b1;
    tick();
    rx = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      rx = i[0];
      tick();
    end
    check("mid_busy_before", rx_busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_busy", rx_busy, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_err", rx_frame_err, 0);
    tick();
    rst = 1'b1;
    rx = 1'b1;
    tick();
    send_frame(14'h1234, 1'b1, 1'b0);
    check("post_rst_data", rx_data, 14'h1234);
    check("post_rst_valid", rx_valid, 1);
    check("post_rst_no_err", err_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
